// File: rtl/downsample_pool2_if.sv
// Stream and control bundle for downsample_pool2: input stream, reduced output
// stream and start/busy/done run control.
interface downsample_pool2_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  start;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_out;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, mode, data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out, busy, done
  );

  modport master (
    output start, mode, data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out, busy, done
  );
endinterface

// File: rtl/downsample_pool2.sv
// Streaming 2x downsampler: each (even, odd) input pair of every channel frame
// is reduced to one Q8.8 sample by rounded average, signed max or decimation.
module downsample_pool2 #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int IN_LEN     = 16
) (
  input  logic             clk,
  input  logic             rst,
  downsample_pool2_if.slave bus
);
  localparam int HALF = IN_LEN / 2;
  localparam int CW   = $clog2(CHANNELS) + 1;
  localparam int PW   = $clog2(HALF) + 1;
  localparam logic [CW-1:0] CH_LAST   = CW'(CHANNELS - 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_SECOND = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CW-1:0]         ch_cnt_r;
  logic [PW-1:0]         pair_cnt_r;
  logic [DATA_WIDTH-1:0] hold_r;
  logic [1:0]            mode_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_out_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  ready_in_s;
  logic                  start_acc_s;
  logic                  first_load_s;
  logic                  pair_load_s;
  logic                  out_xfer_s;
  logic                  last_pair_s;

  // Average rounds half toward +inf; the 17-bit sum keeps (a+b+1)>>>1 exact.
  function automatic logic [DATA_WIDTH-1:0] reduce_pair(
    input logic [1:0]                   m,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] sum;
    sum = (DATA_WIDTH+1)'(a) + (DATA_WIDTH+1)'(b) + (DATA_WIDTH+1)'(1);
    case (m)
      2'd1:    reduce_pair = (b > a) ? b : a;
      2'd2:    reduce_pair = a;
      default: reduce_pair = DATA_WIDTH'(sum >>> 1);
    endcase
  endfunction

  assign out_xfer_s  = valid_out_r && bus.ready_out;
  assign last_pair_s = (pair_cnt_r == PAIR_LAST) && (ch_cnt_r == CH_LAST);

  // Next-state decode and per-state handshake strobes
  always_comb begin
    state_nxt_s  = state_r;
    ready_in_s   = 1'b0;
    start_acc_s  = 1'b0;
    first_load_s = 1'b0;
    pair_load_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          start_acc_s = 1'b1;
          state_nxt_s = S_FIRST;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FIRST: begin
        ready_in_s = 1'b1;
        if (bus.valid_in) begin
          first_load_s = 1'b1;
          state_nxt_s  = S_SECOND;
        end else begin
          state_nxt_s = S_FIRST;
        end
      end
      S_SECOND: begin
        // Only take the odd sample when the output slot is free or freeing.
        ready_in_s = !valid_out_r || bus.ready_out;
        if (bus.valid_in && ready_in_s) begin
          pair_load_s = 1'b1;
          state_nxt_s = last_pair_s ? S_DRAIN : S_FIRST;
        end else begin
          state_nxt_s = S_SECOND;
        end
      end
      S_DRAIN: begin
        if (!valid_out_r || out_xfer_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == S_FIRST) || (state_nxt_s == S_SECOND) ||
                 (state_nxt_s == S_DRAIN);
      done_r  <= (state_nxt_s == S_DONE);
    end
  end

  // Run counters, pair hold register and output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r      <= 2'd0;
      ch_cnt_r    <= '0;
      pair_cnt_r  <= '0;
      hold_r      <= '0;
      data_out_r  <= '0;
      valid_out_r <= 1'b0;
    end else begin
      if (start_acc_s) begin
        mode_r     <= bus.mode;
        ch_cnt_r   <= '0;
        pair_cnt_r <= '0;
      end
      if (first_load_s) begin
        hold_r <= bus.data_in;
      end
      if (pair_load_s) begin
        data_out_r  <= reduce_pair(mode_r, hold_r, bus.data_in);
        valid_out_r <= 1'b1;
        if (pair_cnt_r == PAIR_LAST) begin
          pair_cnt_r <= '0;
          ch_cnt_r   <= ch_cnt_r + CW'(1);
        end else begin
          pair_cnt_r <= pair_cnt_r + PW'(1);
        end
      end else if (out_xfer_s) begin
        valid_out_r <= 1'b0;
      end
    end
  end

  assign bus.ready_in  = ready_in_s;
  assign bus.data_out  = data_out_r;
  assign bus.valid_out = valid_out_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_downsample_pool2.sv
// Directed bench for downsample_pool2 with CHANNELS=2, IN_LEN=4 (4 outputs per run).
module tb_downsample_pool2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [15:0] stim[$];
  logic [15:0] outs[$];
  int out_cyc[$];
  int odd_cyc[$];

  downsample_pool2_if #(.DATA_WIDTH(16)) bus ();

  downsample_pool2 #(.DATA_WIDTH(16), .CHANNELS(2), .IN_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output/done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_out && bus.ready_out) begin
        outs.push_back(bus.data_out);
        out_cyc.push_back(cyc);
      end
      if (bus.done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  // Feeds stim for one run; mode is changed and start re-pulsed mid-run on purpose.
  task automatic drive_run(input logic [1:0] m, input int bubble_pct,
                           input bit rand_ready, input bit stall_en);
    int idx;
    int budget;
    int stall_left;
    logic [15:0] snap;
    idx = 0; budget = 0; stall_left = -1; snap = 16'h0000;
    outs.delete(); out_cyc.delete(); odd_cyc.delete(); done_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = m; bus.valid_in = 1'b0; bus.ready_out = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mode = m ^ 2'b01;
    while (done_cnt == 0 && budget < 300) begin
      bus.start = (budget == 3);
      if (idx < stim.size() && int'($urandom_range(99)) >= bubble_pct) begin
        bus.valid_in = 1'b1; bus.data_in = stim[idx];
      end else begin
        bus.valid_in = 1'b0; bus.data_in = 16'hDEAD;
      end
      if (stall_en && stall_left < 0 && bus.valid_out) begin
        stall_left = 5; snap = bus.data_out;
      end
      if (stall_left > 0) bus.ready_out = 1'b0;
      else if (rand_ready) bus.ready_out = 1'($urandom_range(1));
      else bus.ready_out = 1'b1;
      @(negedge clk);
      if (stall_left > 0) begin
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== snap) begin
          errors++;
          $display("FAIL stall_hold valid=%b data=%h want valid=1 data=%h", bus.valid_out, bus.data_out, snap);
        end
        if (idx[0]) begin
          checks++;
          if (bus.ready_in !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready_in got %b want 0", bus.ready_in);
          end
        end
        stall_left--;
      end
      if (bus.valid_in && bus.ready_in) begin
        if (idx[0]) odd_cyc.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      budget++;
    end
    bus.start = 1'b0; bus.valid_in = 1'b0; bus.ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_pulses got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.mode = 2'd0; bus.data_in = 16'h0000;
    bus.valid_in = 1'b0; bus.ready_out = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.data_out, bus.valid_out, bus.ready_in, bus.busy, bus.done} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_outputs got data=%h v=%b rdy=%b busy=%b done=%b want all 0",
               bus.data_out, bus.valid_out, bus.ready_in, bus.busy, bus.done);
    end
    rst = 1'b0;
    bus.valid_in = 1'b1; bus.data_in = 16'h1234;
    @(posedge clk); #1;
    checks++;
    if (bus.ready_in !== 1'b0 || bus.busy !== 1'b0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_input got rdy=%b busy=%b v=%b want 0 0 0",
               bus.ready_in, bus.busy, bus.valid_out);
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic test_avg();
    logic [15:0] exp_v[4];
    stim = '{16'h0100, 16'h0300, 16'hFF00, 16'hFE00, 16'h0001, 16'h0002, 16'h7FFF, 16'h7FFF};
    exp_v = '{16'h0200, 16'hFE80, 16'h0002, 16'h7FFF};
    drive_run(2'd0, 0, 1'b0, 1'b0);
    checks++;
    if (outs.size() != 4) begin errors++; $display("FAIL avg_count got %0d want 4", outs.size()); end
    foreach (exp_v[i]) begin
      checks++;
      if (i >= outs.size()) begin errors++; $display("FAIL avg_out%0d missing want %h", i, exp_v[i]); end
      else if (outs[i] !== exp_v[i]) begin errors++; $display("FAIL avg_out%0d got %h want %h", i, outs[i], exp_v[i]); end
    end
    foreach (odd_cyc[k]) begin
      checks++;
      if (k >= out_cyc.size() || out_cyc[k] != odd_cyc[k] + 1) begin
        errors++;
        $display("FAIL avg_latency%0d odd sample cycle %0d, output cycle not %0d", k, odd_cyc[k], odd_cyc[k] + 1);
      end
    end
    checks++;
    if (out_cyc.size() == 0 || done_cyc != out_cyc[$] + 1) begin
      errors++;
      $display("FAIL done_timing got cycle %0d want one after last output", done_cyc);
    end
  endtask

  task automatic test_max();
    logic [15:0] exp_v[4];
    stim = '{16'hFF00, 16'h0080, 16'h8000, 16'h8001, 16'h0005, 16'h0005, 16'h1234, 16'h1000};
    exp_v = '{16'h0080, 16'h8001, 16'h0005, 16'h1234};
    drive_run(2'd1, 0, 1'b0, 1'b0);
    checks++;
    if (outs.size() != 4) begin errors++; $display("FAIL max_count got %0d want 4", outs.size()); end
    foreach (exp_v[i]) begin
      checks++;
      if (i >= outs.size()) begin errors++; $display("FAIL max_out%0d missing want %h", i, exp_v[i]); end
      else if (outs[i] !== exp_v[i]) begin errors++; $display("FAIL max_out%0d got %h want %h", i, outs[i], exp_v[i]); end
    end
  endtask

  task automatic test_decimate();
    logic [15:0] exp_v[4];
    stim = '{16'hFF00, 16'h0080, 16'h8000, 16'h8001, 16'h0005, 16'h0005, 16'h1234, 16'h1000};
    exp_v = '{16'hFF00, 16'h8000, 16'h0005, 16'h1234};
    drive_run(2'd2, 0, 1'b0, 1'b0);
    checks++;
    if (outs.size() != 4) begin errors++; $display("FAIL dec_count got %0d want 4", outs.size()); end
    foreach (exp_v[i]) begin
      checks++;
      if (i >= outs.size()) begin errors++; $display("FAIL dec_out%0d missing want %h", i, exp_v[i]); end
      else if (outs[i] !== exp_v[i]) begin errors++; $display("FAIL dec_out%0d got %h want %h", i, outs[i], exp_v[i]); end
    end
  endtask

  task automatic test_rounding();
    logic [15:0] exp_v[4];
    stim = '{16'hFFFF, 16'h0000, 16'h8000, 16'h8001, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};
    exp_v = '{16'h0000, 16'h8001, 16'h8000, 16'h7FFF};
    drive_run(2'd3, 0, 1'b0, 1'b0);
    checks++;
    if (outs.size() != 4) begin errors++; $display("FAIL round_count got %0d want 4", outs.size()); end
    foreach (exp_v[i]) begin
      checks++;
      if (i >= outs.size()) begin errors++; $display("FAIL round_out%0d missing want %h", i, exp_v[i]); end
      else if (outs[i] !== exp_v[i]) begin errors++; $display("FAIL round_out%0d got %h want %h", i, outs[i], exp_v[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_v[4];
    stim = '{16'h0100, 16'h0300, 16'hFF00, 16'hFE00, 16'h0001, 16'h0002, 16'h7FFF, 16'h7FFF};
    exp_v = '{16'h0200, 16'hFE80, 16'h0002, 16'h7FFF};
    drive_run(2'd0, 0, 1'b0, 1'b1);
    checks++;
    if (outs.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", outs.size()); end
    foreach (exp_v[i]) begin
      checks++;
      if (i >= outs.size()) begin errors++; $display("FAIL bp_out%0d missing want %h", i, exp_v[i]); end
      else if (outs[i] !== exp_v[i]) begin errors++; $display("FAIL bp_out%0d got %h want %h", i, outs[i], exp_v[i]); end
    end
  endtask

  task automatic test_bubbles();
    logic [15:0] exp_v[4];
    stim = '{16'hFF00, 16'h0080, 16'h8000, 16'h8001, 16'h0005, 16'h0005, 16'h1234, 16'h1000};
    exp_v = '{16'h0080, 16'h8001, 16'h0005, 16'h1234};
    drive_run(2'd1, 50, 1'b1, 1'b0);
    checks++;
    if (outs.size() != 4) begin errors++; $display("FAIL bub_count got %0d want 4", outs.size()); end
    foreach (exp_v[i]) begin
      checks++;
      if (i >= outs.size()) begin errors++; $display("FAIL bub_out%0d missing want %h", i, exp_v[i]); end
      else if (outs[i] !== exp_v[i]) begin errors++; $display("FAIL bub_out%0d got %h want %h", i, outs[i], exp_v[i]); end
    end
  endtask

  task automatic test_midrun_reset();
    logic [15:0] exp_v[4];
    stim = '{16'h0100, 16'h0300, 16'hFF00, 16'hFE00, 16'h0001, 16'h0002, 16'h7FFF, 16'h7FFF};
    exp_v = '{16'h0200, 16'hFE80, 16'h0002, 16'h7FFF};
    done_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 2'd0; bus.ready_out = 1'b0; bus.valid_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int b;
      bit ok;
      b = 0; ok = 1'b0;
      bus.valid_in = 1'b1; bus.data_in = stim[i];
      while (!ok && b < 20) begin
        @(negedge clk);
        if (bus.ready_in) ok = 1'b1;
        @(posedge clk); #1;
        b++;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_accept%0d got no ready_in want accept", i); end
    end
    bus.valid_in = 1'b0;
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 16'h0200 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending got v=%b data=%h busy=%b want 1 0200 1", bus.valid_out, bus.data_out, bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.data_out, bus.valid_out, bus.ready_in, bus.busy, bus.done} !== 20'h00000) begin
      errors++;
      $display("FAIL async_reset got data=%h v=%b rdy=%b busy=%b done=%b want all 0",
               bus.data_out, bus.valid_out, bus.ready_in, bus.busy, bus.done);
    end
    bus.ready_out = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got done=%0d busy=%b want 0 0", done_cnt, bus.busy);
    end
    drive_run(2'd0, 0, 1'b0, 1'b0);
    checks++;
    if (outs.size() != 4) begin errors++; $display("FAIL fresh_count got %0d want 4", outs.size()); end
    foreach (exp_v[i]) begin
      checks++;
      if (i >= outs.size()) begin errors++; $display("FAIL fresh_out%0d missing want %h", i, exp_v[i]); end
      else if (outs[i] !== exp_v[i]) begin errors++; $display("FAIL fresh_out%0d got %h want %h", i, outs[i], exp_v[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_avg();
    test_max();
    test_decimate();
    test_rounding();
    test_backpressure();
    test_bubbles();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/downsample_pool2.md
Name: downsample_pool2

Overview:
- Streaming 2x downsampler: the inverse-direction companion to the nearest-neighbour upsampler, used in the discriminator/encoder path of the OFDM GAN.
- Consumes CHANNELS frames of IN_LEN Q8.8 samples (channel-major) and emits IN_LEN/2 samples per channel.
- Each output is formed from one adjacent input pair (even index, odd index) by average, max, or decimate, selected per run.
- Valid/ready stream on both sides, registered output, start/busy/done control.

Parameters:
- DATA_WIDTH, 16, sample width, signed Q8.8.
- CHANNELS, 4, frames per run.
- IN_LEN, 16, input samples per channel; must be even and >= 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- mode  in  2  pair reduction: 0 = rounded average, 1 = signed max, 2 = decimate (keep even sample), 3 = same as 0; latched at start.
- data_in  in  DATA_WIDTH  signed input sample.
- valid_in  in  1  data_in valid.
- ready_in  out  1  block accepts data_in this cycle.
- data_out  out  DATA_WIDTH  signed reduced sample (registered).
- valid_out  out  1  data_out valid; held until accepted.
- ready_out  in  1  downstream accepts data_out.
- busy  out  1  high in FIRST, SECOND, DRAIN.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset: state=IDLE; counters 0; hold_reg 0; mode_reg 0; data_out 0; valid_out 0; ready_in 0; busy 0; done 0. Reset mid-run aborts immediately: no done pulse, any pending output is discarded.
- Input transfer occurs when valid_in && ready_in. Output transfer occurs when valid_out && ready_out.
- IDLE: ready_in=0. start=1 latches mode into mode_reg, clears pair_cnt and ch_cnt, and moves to FIRST. start is ignored in every other state.
- FIRST: ready_in=1. On transfer: hold_reg <= data_in, then go to SECOND.
- SECOND: ready_in = !valid_out || ready_out, so the output slot must be free or freeing this cycle. On transfer:
  - data_out <= reduce(hold_reg, data_in) and valid_out <= 1.
  - pair_cnt increments. At IN_LEN/2-1 it wraps to 0 and ch_cnt increments.
  - If that pair was the last pair of channel CHANNELS-1, go to DRAIN; otherwise go to FIRST.
- Output register: valid_out clears on an output transfer unless a new result loads in the same cycle. A simultaneous load and accept gives back-to-back valid with the new data. data_out holds its value while valid_out=1 && ready_out=0.
- DRAIN: ready_in=0. Once valid_out==0, or an output transfer happens this cycle, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE. A start asserted during DONE is ignored.
- Latency: the output is valid in the cycle after the odd-sample transfer. Sustained throughput is 1 output per 2 input beats with ready_out held high.
- Arithmetic:
  - avg: sum = 17-bit sign-extended a+b; result = (sum+1)>>>1, i.e. round half toward +inf. The result always fits 16 bits: 0x7FFF,0x7FFF -> 0x7FFF; 0x8000,0x8000 -> 0x8000.
  - max: signed compare; on a tie, a is selected.
  - decimate: result = a (the even sample); b is consumed and dropped.
- ch_cnt width is $clog2(CHANNELS)+1 and pair_cnt width is $clog2(IN_LEN/2)+1, so neither counter overflows when a parameter is a power of two.
- valid_in is ignored in IDLE, DRAIN and DONE; the block does not consume those samples.

Test Plan:
- CHANNELS=2, IN_LEN=4, mode=0, ready_out=1, input 0x0100,0x0300,0xFF00,0xFE00 / 0x0001,0x0002,0x7FFF,0x7FFF -> outputs 0x0200,0xFE80,0x0002,0x7FFF; valid each cycle after the odd sample; done pulses once, exactly 1 cycle after the last output transfer.
- mode=1, pairs (0xFF00,0x0080),(0x8000,0x8001) -> 0x0080,0x8001. mode=2, same pairs -> 0xFF00,0x8000.
- Backpressure: ready_out=0 for 5 cycles after the first output -> data_out and valid_out stable; ready_in=0 in SECOND; no sample lost; the sequence matches the ready_out=1 run.
- Bubbles: valid_in randomly low 50% of cycles with ready_out random -> output sequence identical to the golden model; no duplicate or dropped outputs.
- Mid-run: mode changed to 1 after start -> results still use the latched mode 0; start pulsed while busy is ignored; rst asserted after 3 inputs -> all outputs return to 0 asynchronously, no done; a fresh start then completes correctly.
- Rounding: avg(0xFFFF,0x0000) -> 0x0000; avg(0x8000,0x8001) -> 0x8001; avg(0x8000,0x8000) -> 0x8000.
